// File: rtl/csr_regfile.sv
// Parametrised CSR register file: per-register access mode, bit mask and reset value,
// byte enables, sticky read-to-clear capture, 1-cycle req/ack handshake. Optional: CSR_BUS_ERR_EN.

module csr_reg_slot #(
    parameter int              DATA_W = 32,
    parameter logic [1:0]      MODE   = 2'd0,
    parameter logic [DATA_W-1:0] MASK = '1,
    parameter logic [DATA_W-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0] wdat,
    input  logic [DATA_W-1:0] hw_d,
    input  logic              hw_set,
    output logic [DATA_W-1:0] value,
    output logic [DATA_W-1:0] rd_val
);
    localparam logic [1:0] WR_RD    = 2'd0;
    localparam logic [1:0] WO_PULSE = 2'd1;
    localparam logic [1:0] RD_ONLY  = 2'd2;

    logic [DATA_W-1:0] bmask;
    logic [DATA_W-1:0] wdat_m;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < DATA_W/8; b++) bmask[b*8 +: 8] = {8{be[b]}};
        wdat_m = wdat & bmask & MASK;
    end

    // Every mode uses only a subset of the inputs; fold the rest here.
    logic unused_ok;
    assign unused_ok = ^{clk, srst, wr_en, rd_en, wdat_m, hw_d, hw_set};

    generate
        if (MODE == WR_RD) begin : g_wr_rd
            logic [DATA_W-1:0] val_q, val_d;
            always_comb val_d = wr_en ? ((val_q & ~(bmask & MASK)) | wdat_m) : val_q;
            always_ff @(posedge clk) begin
                if (srst) val_q <= INIT & MASK;
                else      val_q <= val_d;
            end
            assign value  = val_q;
            assign rd_val = val_q;
        end else if (MODE == WO_PULSE) begin : g_wo_pulse
            logic [DATA_W-1:0] val_q, val_d;
            always_comb val_d = wr_en ? wdat_m : '0;
            always_ff @(posedge clk) begin
                if (srst) val_q <= '0;
                else      val_q <= val_d;
            end
            assign value  = val_q;
            assign rd_val = '0;
        end else if (MODE == RD_ONLY) begin : g_rd_only
            assign value  = hw_d & MASK;
            assign rd_val = hw_d & MASK;
        end else begin : g_rd_clr
            logic [DATA_W-1:0] cap_q, cap_d;
            // A read clears first, so a same-edge hw_set lands in the fresh capture.
            always_comb begin
                cap_d = rd_en ? '0 : cap_q;
                if (hw_set) cap_d = cap_d | (hw_d & MASK);
            end
            always_ff @(posedge clk) begin
                if (srst) cap_q <= '0;
                else      cap_q <= cap_d;
            end
            assign value  = cap_q;
            assign rd_val = cap_q;
        end
    endgenerate
endmodule

module csr_regfile #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter logic [2*NUM_REGS-1:0]      REG_MODE = {2'd1, 2'd0, 2'd3, 2'd1, 2'd0},
    parameter logic [NUM_REGS*DATA_W-1:0] REG_MASK = {32'h1, 32'h7FFF, 32'h800000FF, 32'h1, 32'hFF},
    parameter logic [NUM_REGS*DATA_W-1:0] REG_INIT = '0
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       bus_req,
    input  logic                       bus_we,
    input  logic [ADDR_W-1:0]          bus_addr,
    input  logic [DATA_W/8-1:0]        bus_be,
    input  logic [DATA_W-1:0]          bus_wdat,
    output logic                       bus_ack,
    output logic [DATA_W-1:0]          bus_rdat,
    output logic                       bus_err,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wstb,
    input  logic [NUM_REGS*DATA_W-1:0] hw_d,
    input  logic [NUM_REGS-1:0]        hw_set
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic [NUM_REGS-1:0] wstb_q, wstb_d;

    logic                accept;
    logic [NUM_REGS-1:0] hit, wr_en, rd_en;
    logic [NUM_REGS-1:0][DATA_W-1:0] hw_d_a, val_a, rd_val;
    logic [DATA_W-1:0]   rd_sel;

    assign hw_d_a = hw_d;
    assign reg_q  = val_a;
    assign accept = (state_q == S_IDLE) && bus_req;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            assign hit[i]   = (bus_addr == ADDR_W'(i));
            assign wr_en[i] = accept && bus_we && hit[i];
            assign rd_en[i] = accept && !bus_we && hit[i];
            csr_reg_slot #(
                .DATA_W (DATA_W),
                .MODE   (REG_MODE[2*i +: 2]),
                .MASK   (REG_MASK[i*DATA_W +: DATA_W]),
                .INIT   (REG_INIT[i*DATA_W +: DATA_W])
            ) u_slot (
                .clk    (clk),
                .srst   (srst),
                .wr_en  (wr_en[i]),
                .rd_en  (rd_en[i]),
                .be     (bus_be),
                .wdat   (bus_wdat),
                .hw_d   (hw_d_a[i]),
                .hw_set (hw_set[i]),
                .value  (val_a[i]),
                .rd_val (rd_val[i])
            );
        end
    endgenerate

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) if (hit[i]) rd_sel = rd_val[i];
    end

    always_comb begin
        state_d = accept ? S_ACK : S_IDLE;
        ack_d   = accept;
        wstb_d  = wr_en;
        rdat_d  = (accept && !bus_we) ? rd_sel : '0;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
            wstb_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            wstb_q  <= wstb_d;
        end
    end

    assign bus_ack  = ack_q;
    assign bus_rdat = rdat_q;
    assign reg_wstb = wstb_q;

`ifdef CSR_BUS_ERR_EN
    logic                err_q, err_d;
    logic [NUM_REGS-1:0] ro_m, wo_m;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_err
            assign ro_m[i] = REG_MODE[2*i+1];
            assign wo_m[i] = (REG_MODE[2*i +: 2] == 2'd1);
        end
    endgenerate

    always_comb err_d = accept && (!(|hit) || (bus_we && |(hit & ro_m)) || (!bus_we && |(hit & wo_m)));

    always_ff @(posedge clk) begin
        if (srst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios plus randomized traffic against
// a register-map model (modes/masks written out as a table).
module tb_csr_regfile;
    localparam int N  = 5;
    localparam int DW = 32;
    localparam int AW = 3;
`ifdef CSR_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          srst, bus_req, bus_we, bus_ack, bus_err;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [DW-1:0] bus_wdat, bus_rdat;
    logic [N*DW-1:0] reg_q, hw_d;
    logic [N-1:0]  reg_wstb, hw_set;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_val [N];
    logic [31:0] m_cap [N];

    always #5 clk = ~clk;

    csr_regfile dut (
        .clk(clk), .srst(srst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdat(bus_wdat), .bus_ack(bus_ack), .bus_rdat(bus_rdat),
        .bus_err(bus_err), .reg_q(reg_q), .reg_wstb(reg_wstb), .hw_d(hw_d), .hw_set(hw_set)
    );

    // 0=WR_RD 1=WO_PULSE 2=RD_ONLY 3=RD_CLR
    function automatic int mode_of(input int i);
        case (i)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        case (i)
            0: return 32'hFF;
            1: return 32'h1;
            2: return 32'h8000_00FF;
            3: return 32'h7FFF;
            default: return 32'h1;
        endcase
    endfunction

    function automatic logic [31:0] word_of(input logic [N*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_val[i] = 32'h0;
            m_cap[i] = 32'h0;
        end
    endtask

    task automatic access(input string tag, input logic we, input int addr, input logic [3:0] be,
                          input logic [31:0] wdat, input logic [N-1:0] hs, input logic [31:0] hd);
        logic [31:0] exp_rd, mk;
        logic [31:0] pulse [N];
        logic [31:0] exp_q;
        logic        exp_err;
        logic [N-1:0] exp_wstb;
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = addr[AW-1:0]; bus_be = be; bus_wdat = wdat;
        hw_set = hs; hw_d = {N{hd}};
        exp_rd = 0; exp_err = 0; exp_wstb = 0;
        for (int i = 0; i < N; i++) pulse[i] = 0;
        if (addr >= N) exp_err = ERR_EN;
        else begin
            mk = mask_of(addr);
            if (we) begin
                exp_wstb[addr] = 1'b1;
                case (mode_of(addr))
                    0: for (int b = 0; b < 4; b++)
                           if (be[b]) m_val[addr][b*8 +: 8] = wdat[b*8 +: 8] & mk[b*8 +: 8];
                    1: for (int b = 0; b < 4; b++)
                           if (be[b]) pulse[addr][b*8 +: 8] = wdat[b*8 +: 8] & mk[b*8 +: 8];
                    default: exp_err = ERR_EN;
                endcase
            end else begin
                case (mode_of(addr))
                    0: exp_rd = m_val[addr];
                    1: exp_err = ERR_EN;
                    2: exp_rd = hd & mk;
                    default: begin exp_rd = m_cap[addr]; m_cap[addr] = 0; end
                endcase
            end
        end
        for (int i = 0; i < N; i++)
            if (mode_of(i) == 3 && hs[i]) m_cap[i] = m_cap[i] | (hd & mask_of(i));
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b1) begin errors++; $display("FAIL %s ack: got %b exp 1", tag, bus_ack); end
        checks++;
        if (bus_err !== exp_err) begin errors++; $display("FAIL %s err: got %b exp %b", tag, bus_err, exp_err); end
        checks++;
        if (reg_wstb !== exp_wstb) begin errors++; $display("FAIL %s wstb: got %b exp %b", tag, reg_wstb, exp_wstb); end
        if (!we) begin
            checks++;
            if (bus_rdat !== exp_rd) begin errors++; $display("FAIL %s rdat: got %h exp %h", tag, bus_rdat, exp_rd); end
        end
        for (int i = 0; i < N; i++) begin
            case (mode_of(i))
                0: exp_q = m_val[i];
                1: exp_q = pulse[i];
                2: exp_q = hd & mask_of(i);
                default: exp_q = m_cap[i];
            endcase
            checks++;
            if (word_of(reg_q, i) !== exp_q) begin
                errors++; $display("FAIL %s reg_q[%0d]: got %h exp %h", tag, i, word_of(reg_q, i), exp_q);
            end
        end
        bus_req = 1'b0; hw_set = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0 || reg_wstb !== '0) begin
            errors++; $display("FAIL %s ack_end: got ack=%b wstb=%b exp 0/0", tag, bus_ack, reg_wstb);
        end
        for (int i = 0; i < N; i++) if (mode_of(i) == 1) begin
            checks++;
            if (word_of(reg_q, i) !== 32'h0) begin
                errors++; $display("FAIL %s pulse_end[%0d]: got %h exp 0", tag, i, word_of(reg_q, i));
            end
        end
    endtask

    task automatic hw_event(input string tag, input logic [N-1:0] hs, input logic [31:0] hd);
        @(negedge clk);
        hw_set = hs; hw_d = {N{hd}};
        for (int i = 0; i < N; i++)
            if (mode_of(i) == 3 && hs[i]) m_cap[i] = m_cap[i] | (hd & mask_of(i));
        @(posedge clk);
        @(negedge clk);
        hw_set = '0;
        for (int i = 0; i < N; i++) if (mode_of(i) == 3) begin
            checks++;
            if (word_of(reg_q, i) !== m_cap[i]) begin
                errors++; $display("FAIL %s cap[%0d]: got %h exp %h", tag, i, word_of(reg_q, i), m_cap[i]);
            end
        end
    endtask

    task automatic test_reset();
        srst = 1'b1; bus_req = 0; bus_we = 0; bus_addr = 0; bus_be = 0; bus_wdat = 0;
        hw_d = '0; hw_set = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0 || bus_err !== 1'b0 || bus_rdat !== 32'h0 || reg_wstb !== '0) begin
            errors++; $display("FAIL reset_outs: got ack=%b err=%b rdat=%h wstb=%b exp all 0",
                               bus_ack, bus_err, bus_rdat, reg_wstb);
        end
        checks++;
        if (reg_q !== '0) begin errors++; $display("FAIL reset_regq: got %h exp 0", reg_q); end
        srst = 1'b0;
        access("rst_rd0", 1'b0, 0, 4'h0, 32'h0, '0, 32'h0);
        access("rst_rd3", 1'b0, 3, 4'h0, 32'h0, '0, 32'h0);
    endtask

    task automatic test_byte_enable();
        access("be_wr0", 1'b1, 0, 4'b0001, 32'hA5A5_1234, '0, 32'h0);
        access("be_rd0", 1'b0, 0, 4'h0, 32'h0, '0, 32'h0);
        access("be_wr1", 1'b1, 0, 4'b0010, 32'hA5A5_1234, '0, 32'h0);
        access("be_rd1", 1'b0, 0, 4'h0, 32'h0, '0, 32'h0);
        access("be_wr3", 1'b1, 3, 4'b0011, 32'hFFFF_FFFF, '0, 32'h0);
        access("be_wr3b", 1'b1, 3, 4'b0001, 32'h0000_0000, '0, 32'h0);
        access("be_rd3", 1'b0, 3, 4'h0, 32'h0, '0, 32'h0);
    endtask

    task automatic test_wo_pulse();
        access("wo_wr1", 1'b1, 1, 4'hF, 32'h1, '0, 32'h0);
        access("wo_rd1", 1'b0, 1, 4'h0, 32'h0, '0, 32'h0);
        access("wo_wr4", 1'b1, 4, 4'hE, 32'hFFFF_FFFF, '0, 32'h0);
    endtask

    task automatic test_rd_clr();
        hw_event("rc_set", 5'b00100, 32'h8000_0041);
        access("rc_rd1", 1'b0, 2, 4'h0, 32'h0, '0, 32'h0);
        access("rc_rd2", 1'b0, 2, 4'h0, 32'h0, '0, 32'h0);
        hw_event("rc_set2", 5'b00100, 32'h8000_0041);
        access("rc_rdset", 1'b0, 2, 4'h0, 32'h0, 5'b00100, 32'h8000_0007);
        access("rc_rdnew", 1'b0, 2, 4'h0, 32'h0, '0, 32'h0);
        hw_event("rc_or1", 5'b00100, 32'h0000_0F10);
        hw_event("rc_or2", 5'b00100, 32'h7000_0003);
        access("rc_rdor", 1'b0, 2, 4'h0, 32'h0, '0, 32'h0);
    endtask

    task automatic test_err();
        hw_event("err_set", 5'b00100, 32'h8000_0022);
        access("err_rd7", 1'b0, 7, 4'h0, 32'h0, '0, 32'h0);
        access("err_wr7", 1'b1, 7, 4'hF, 32'hFFFF_FFFF, '0, 32'h0);
        access("err_wr2", 1'b1, 2, 4'hF, 32'h0000_00FF, '0, 32'h0);
        access("err_rd1", 1'b0, 1, 4'h0, 32'h0, '0, 32'h0);
        access("err_rd2", 1'b0, 2, 4'h0, 32'h0, '0, 32'h0);
    endtask

    task automatic test_srst_drop();
        access("drop_pre", 1'b1, 3, 4'hF, 32'h0000_0055, '0, 32'h0);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 3'd3; bus_be = 4'hF; bus_wdat = 32'h1234;
        srst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0 || reg_wstb !== '0) begin
            errors++; $display("FAIL drop_ack: got ack=%b wstb=%b exp 0/0", bus_ack, reg_wstb);
        end
        checks++;
        if (word_of(reg_q, 3) !== 32'h0) begin
            errors++; $display("FAIL drop_reg3: got %h exp 0", word_of(reg_q, 3));
        end
        bus_req = 1'b0; srst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_ack !== 1'b0) begin errors++; $display("FAIL drop_noack: got %b exp 0", bus_ack); end
        access("drop_post", 1'b0, 3, 4'h0, 32'h0, '0, 32'h0);
    endtask

    task automatic test_back_to_back();
        access("b2b_wr0", 1'b1, 0, 4'hF, 32'h0000_00C3, '0, 32'h0);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 3'd0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus_ack !== ((k % 2) == 0)) begin
                errors++; $display("FAIL b2b_ack%0d: got %b exp %b", k, bus_ack, (k % 2) == 0);
            end
            if ((k % 2) == 0) begin
                checks++;
                if (bus_rdat !== m_val[0]) begin
                    errors++; $display("FAIL b2b_rdat%0d: got %h exp %h", k, bus_rdat, m_val[0]);
                end
            end
        end
        bus_req = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 250; n++) begin
            logic [N-1:0] hs;
            hs = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 4) == 0)
                hw_event("rnd_hw", hs, $urandom);
            else
                access("rnd", 1'($urandom), int'($urandom_range(0, 7)), 4'($urandom), $urandom, hs, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_wo_pulse();
        test_rd_clr();
        test_err();
        test_srst_drop();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
